// File: rtl/pc_gen.sv
// Fetch program-counter generator: issues PCs over valid/ready, advances by STEP,
// takes prioritised redirects and stamps each PC with a wrapping epoch tag.
module pc_gen #(
    parameter int unsigned            WIDTH     = 32,
    parameter logic [WIDTH-1:0]       RESET_VEC = WIDTH'(32'h0000_0060),
    parameter int unsigned            STEP      = 4,
    parameter int unsigned            NRED      = 3,
    parameter int unsigned            EPOCH_W   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NRED-1:0]         redir_valid,
    input  logic [NRED*WIDTH-1:0]   redir_pc,
    input  logic                    halt_req,
    input  logic                    pc_ready,
    output logic                    pc_valid,
    output logic [WIDTH-1:0]        pc,
    output logic [EPOCH_W-1:0]      pc_epoch,
    output logic                    pc_misaligned,
    output logic                    halted
);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        HALTED
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH-1:0]     pc_q, pc_d;
    logic [EPOCH_W-1:0]   epoch_q, epoch_d;

    logic                 fire;
    logic                 redir_any;
    logic [WIDTH-1:0]     redir_tgt;

    // Scan from the highest channel down so the lowest set index is the last write.
    always_comb begin
        redir_tgt = '0;
        for (int unsigned i = NRED; i > 0; i--) begin
            if (redir_valid[i-1]) begin
                redir_tgt = redir_pc[(i-1)*WIDTH +: WIDTH];
            end
        end
    end

    assign redir_any = |redir_valid;
    assign fire      = (state_q == RUN) && pc_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        epoch_d = epoch_q;

        // Redirect overrides the fetch advance; a same-cycle fire was issued under the old epoch.
        if (redir_any) begin
            pc_d    = redir_tgt;
            epoch_d = epoch_q + EPOCH_W'(1);
        end else if (fire) begin
            pc_d    = pc_q + WIDTH'(STEP);
        end

        case (state_q)
            BOOT:    state_d = halt_req ? HALTED : RUN;
            RUN:     state_d = halt_req ? HALTED : RUN;
            HALTED:  state_d = halt_req ? HALTED : RUN;
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
            pc_q    <= RESET_VEC;
            epoch_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            epoch_q <= epoch_d;
        end
    end

    assign pc            = pc_q;
    assign pc_epoch      = epoch_q;
    assign pc_valid      = (state_q == RUN);
    assign halted        = (state_q == HALTED);
    assign pc_misaligned = (pc_q[1:0] != 2'b00);

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: directed vector table, hand-written corner
// sequences and randomized traffic against a behavioural model.
module tb_pc_gen;

    logic        clk;
    logic        rst;
    logic [2:0]  redir_valid;
    logic [95:0] redir_pc;
    logic        halt_req;
    logic        pc_ready;
    logic        pc_valid;
    logic [31:0] pc;
    logic [2:0]  pc_epoch;
    logic        pc_misaligned;
    logic        halted;

    int checks = 0;
    int errors = 0;

    pc_gen #(
        .WIDTH     (32),
        .RESET_VEC (32'h0000_0060),
        .STEP      (4),
        .NRED      (3),
        .EPOCH_W   (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .redir_valid   (redir_valid),
        .redir_pc      (redir_pc),
        .halt_req      (halt_req),
        .pc_ready      (pc_ready),
        .pc_valid      (pc_valid),
        .pc            (pc),
        .pc_epoch      (pc_epoch),
        .pc_misaligned (pc_misaligned),
        .halted        (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model: boot/halt flags, pc and epoch as plain integers.
    bit          m_boot;
    bit          m_halt;
    logic [31:0] m_pc;
    int          m_ep;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_update(input bit r, input logic [2:0] rv,
                                input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                                input bit h, input bit rd);
        logic [31:0] tg[3];
        bit found;
        bit fired;
        if (r) begin
            m_boot = 1'b1;
            m_halt = 1'b0;
            m_pc   = 32'h60;
            m_ep   = 0;
        end else begin
            tg[0] = p0; tg[1] = p1; tg[2] = p2;
            fired = !m_boot && !m_halt && rd;
            found = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (rv[i] && !found) begin
                    found = 1'b1;
                    m_pc  = tg[i];
                end
            end
            if (found) m_ep = (m_ep + 1) % 8;
            else if (fired) m_pc = m_pc + 32'd4;
            m_boot = 1'b0;
            m_halt = h;
        end
    endtask

    task automatic step(input bit r, input logic [2:0] rv,
                        input logic [31:0] p0, input logic [31:0] p1, input logic [31:0] p2,
                        input bit h, input bit rd);
        rst         = r;
        redir_valid = rv;
        redir_pc    = {p2, p1, p0};
        halt_req    = h;
        pc_ready    = rd;
        @(posedge clk);
        model_update(r, rv, p0, p1, p2, h, rd);
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pc"},     pc,                     m_pc);
        chk({tag, ".epoch"},  {29'd0, pc_epoch},      32'(m_ep));
        chk({tag, ".valid"},  {31'd0, pc_valid},      {31'd0, !m_boot && !m_halt});
        chk({tag, ".halted"}, {31'd0, halted},        {31'd0, m_halt});
        chk({tag, ".mis"},    {31'd0, pc_misaligned}, {31'd0, m_pc[1:0] != 2'b00});
    endtask

    typedef struct {
        bit          r;
        logic [2:0]  rv;
        logic [31:0] p0, p1, p2;
        bit          h, rd;
        logic [31:0] e_pc;
        int          e_ep;
        bit          e_v, e_h, e_m;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit r, logic [2:0] rv, logic [31:0] p0, logic [31:0] p1,
                                logic [31:0] p2, bit h, bit rd, logic [31:0] e_pc,
                                int e_ep, bit e_v, bit e_h, bit e_m);
        vec_t v;
        v.r = r; v.rv = rv; v.p0 = p0; v.p1 = p1; v.p2 = p2; v.h = h; v.rd = rd;
        v.e_pc = e_pc; v.e_ep = e_ep; v.e_v = e_v; v.e_h = e_h; v.e_m = e_m;
        vt.push_back(v);
    endfunction

    initial begin
        logic [2:0]  rv;
        logic [31:0] p[3];
        bit          h;
        rst = 1'b1; redir_valid = '0; redir_pc = '0; halt_req = 1'b0; pc_ready = 1'b0;

        //  r  rv      p0            p1         p2         h  rd  e_pc          ep v  h  m
        add(1, 3'b000, 0,            0,         0,         0, 1, 32'h60,       0, 0, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h60,       0, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h64,       0, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h68,       0, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h6C,       0, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h70,       0, 1, 0, 0);
        for (int i = 0; i < 5; i++)
            add(0, 3'b000, 0,        0,         0,         0, 0, 32'h70,       0, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h74,       0, 1, 0, 0);
        add(0, 3'b110, 0,            32'h200,   32'h300,   0, 0, 32'h200,      1, 1, 0, 0);
        add(0, 3'b111, 32'h100,      32'h200,   32'h300,   0, 0, 32'h100,      2, 1, 0, 0);
        add(0, 3'b001, 32'h80,       0,         0,         0, 0, 32'h80,       3, 1, 0, 0);
        add(0, 3'b001, 32'h400,      0,         0,         0, 1, 32'h400,      4, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h404,      4, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         1, 1, 32'h408,      4, 0, 1, 0);
        add(0, 3'b100, 0,            0,         32'h500,   1, 0, 32'h500,      5, 0, 1, 0);
        add(0, 3'b000, 0,            0,         0,         0, 0, 32'h500,      5, 1, 0, 0);
        add(0, 3'b001, 32'hFFFFFFFC, 0,         0,         0, 0, 32'hFFFFFFFC, 6, 1, 0, 0);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h0,        6, 1, 0, 0);
        add(0, 3'b001, 32'h102,      0,         0,         0, 0, 32'h102,      7, 1, 0, 1);
        add(0, 3'b000, 0,            0,         0,         0, 1, 32'h106,      7, 1, 0, 1);
        add(0, 3'b000, 0,            0,         0,         0, 0, 32'h106,      7, 1, 0, 1);
        add(1, 3'b000, 0,            0,         0,         0, 0, 32'h60,       0, 0, 0, 0);

        for (int i = 0; i < vt.size(); i++) begin
            step(vt[i].r, vt[i].rv, vt[i].p0, vt[i].p1, vt[i].p2, vt[i].h, vt[i].rd);
            chk($sformatf("vec%0d.pc", i),     pc,                     vt[i].e_pc);
            chk($sformatf("vec%0d.epoch", i),  {29'd0, pc_epoch},      32'(vt[i].e_ep));
            chk($sformatf("vec%0d.valid", i),  {31'd0, pc_valid},      {31'd0, vt[i].e_v});
            chk($sformatf("vec%0d.halted", i), {31'd0, halted},        {31'd0, vt[i].e_h});
            chk($sformatf("vec%0d.mis", i),    {31'd0, pc_misaligned}, {31'd0, vt[i].e_m});
        end

        // Epoch wrap: climb to 7, then eight more redirects come back to 7 via 0.
        step(0, 3'b000, 0, 0, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 3'b010, 0, 32'h1000 + 32'(i * 16), 0, 0, 1);
        chk("wrap.start", {29'd0, pc_epoch}, 32'd7);
        step(0, 3'b001, 32'h2000, 0, 0, 0, 1);
        chk("wrap.zero", {29'd0, pc_epoch}, 32'd0);
        for (int i = 0; i < 7; i++) begin
            step(0, 3'b100, 0, 0, 32'h3000 + 32'(i * 4), 0, 1);
            check_model("wrap");
        end
        chk("wrap.end", {29'd0, pc_epoch}, 32'd7);

        // Halt requested during BOOT goes straight to HALTED.
        step(1, 3'b000, 0, 0, 0, 1, 1);
        step(0, 3'b000, 0, 0, 0, 1, 1);
        chk("boot_halt.halted", {31'd0, halted},   32'd1);
        chk("boot_halt.valid",  {31'd0, pc_valid}, 32'd0);
        chk("boot_halt.pc",     pc,                32'h60);

        // Redirect during BOOT overrides the reset vector.
        step(1, 3'b000, 0, 0, 0, 0, 1);
        step(0, 3'b001, 32'h300, 0, 0, 0, 1);
        chk("boot_redir.pc",    pc,                32'h300);
        chk("boot_redir.epoch", {29'd0, pc_epoch}, 32'd1);
        chk("boot_redir.valid", {31'd0, pc_valid}, 32'd1);
        step(0, 3'b000, 0, 0, 0, 0, 1);
        chk("boot_redir.adv",   pc,                32'h304);

        // Randomized traffic against the model.
        h = 1'b0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < 3; i++) begin
                p[i] = {$urandom() & 32'hFFFF_FFFC};
                if ($urandom_range(0, 7) == 0) p[i][1:0] = 2'($urandom());
            end
            rv = ($urandom_range(0, 5) == 0) ? 3'($urandom()) : 3'b000;
            if ($urandom_range(0, 15) == 0) h = ~h;
            step($urandom_range(0, 99) == 0, rv, p[0], p[1], p[2], h, 1'($urandom()));
            check_model("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
